// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - shared flit layout, direction and arbiter state types for the NoC router
//
// Contents:
//   FLIT_W, HEAD_BIT, TAIL_BIT, DST_MSB/DST_LSB : flit field positions
//   dir_e                                       : router port index (Core,E,N,W,S)
//   arb_state_e                                 : output-port arbiter FSM states
//   rr_next()                                   : round-robin pointer advance with wrap
package noc_pkg;

  localparam int FLIT_W   = 34;
  localparam int HEAD_BIT = 33;
  localparam int TAIL_BIT = 32;
  localparam int DST_MSB  = 27;
  localparam int DST_LSB  = 24;

  typedef enum logic [2:0] {
    DIR_CORE = 3'd0,
    DIR_E    = 3'd1,
    DIR_N    = 3'd2,
    DIR_W    = 3'd3,
    DIR_S    = 3'd4
  } dir_e;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND      = 2'd1,
    WAIT_BODY = 2'd2
  } arb_state_e;

  // Pointer moves to the input just after the one that finished, wrapping at n-1.
  function automatic logic [2:0] rr_next(input logic [2:0] id, input int n);
    return (id == 3'(n - 1)) ? 3'd0 : id + 3'd1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational rotating-priority picker
//
// Ports:
//   i_req    [N-1:0] request vector
//   i_ptr    [2:0]   index holding highest priority this cycle
//   o_onehot [N-1:0] one-hot winner (zero when no request)
//   o_idx    [2:0]   winner index (0 when no request)
//   o_valid          at least one request present
module rr_pick #(
  parameter int N = 5
) (
  input  logic [N-1:0] i_req,
  input  logic [2:0]   i_ptr,
  output logic [N-1:0] o_onehot,
  output logic [2:0]   o_idx,
  output logic         o_valid
);

  int w_j;

  // Scan offsets from farthest to nearest so the request closest to i_ptr
  // (walking upward with wrap) is the last one written and therefore wins.
  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
    o_valid  = 1'b0;
    w_j      = 0;
    for (int k = N - 1; k >= 0; k--) begin
      w_j = int'(i_ptr) + k;
      if (w_j >= N) w_j = w_j - N;
      if (i_req[w_j]) begin
        o_onehot      = '0;
        o_onehot[w_j] = 1'b1;
        o_idx         = 3'(w_j);
        o_valid       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/noc_output_port_arbiter.sv
// rtl/noc_output_port_arbiter.sv - round-robin wormhole arbiter for one router output port
//
// Optional feature: define ARB_PERF_CNT_EN to build the pkt_cnt/stall_cnt counters;
// otherwise both outputs are tied to zero.
//
// Ports:
//   clk, rst    clock and synchronous active-low reset
//   route_req   per-input request: input i holds a flit for this port
//   in_flit     packed input flits, input i at [i*FLIT_W +: FLIT_W]
//   src_ack     one-cycle pulse: flit of input i is consumed this cycle
//   out_flit    registered flit to downstream, valid while out_req=1
//   out_req     out_flit valid, held until in_ack
//   in_ack      downstream accepts out_flit
//   grant_id    input currently locked (meaningful while busy=1)
//   busy        a packet holds the port
//   err_orphan  pulse: non-head flit requested while idle
//   pkt_cnt     completed packets (saturating)
//   stall_cnt   cycles locked waiting for body flits (saturating)
module noc_output_port_arbiter
  import noc_pkg::*;
#(
  parameter int NUM_IN  = 5,
  parameter int FLIT_W  = noc_pkg::FLIT_W,
  parameter int PORT_ID = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_IN-1:0]        route_req,
  input  logic [NUM_IN*FLIT_W-1:0] in_flit,
  output logic [NUM_IN-1:0]        src_ack,
  output logic [FLIT_W-1:0]        out_flit,
  output logic                     out_req,
  input  logic                     in_ack,
  output logic [2:0]               grant_id,
  output logic                     busy,
  output logic                     err_orphan,
  output logic [15:0]              pkt_cnt,
  output logic [15:0]              stall_cnt
);

  if (NUM_IN < 1 || NUM_IN > 8 || FLIT_W <= HEAD_BIT || PORT_ID < 0 || PORT_ID > 7) begin : g_bad_cfg
    $error("noc_output_port_arbiter: unsupported NUM_IN/FLIT_W/PORT_ID");
  end

  arb_state_e          r_state, w_state_nxt;
  logic [2:0]          r_rr_ptr, r_grant_id;
  logic [FLIT_W-1:0]   r_out_flit, w_sel_flit;
  logic                r_out_req, r_busy;

  logic [NUM_IN-1:0]   w_head, w_grant_onehot, w_pick_onehot, w_src_ack;
  logic [2:0]          w_pick_idx, w_sel_idx;
  logic                w_pick_valid, w_orphan, w_grant_req;
  logic                w_load, w_tail_done, w_bubble;

  always_comb begin
    w_head         = '0;
    w_grant_onehot = '0;
    w_sel_flit     = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      w_head[i]         = in_flit[i*FLIT_W + HEAD_BIT];
      w_grant_onehot[i] = (r_grant_id == 3'(i));
      if (w_sel_idx == 3'(i)) w_sel_flit = in_flit[i*FLIT_W +: FLIT_W];
    end
  end

  // Only head flits may open a packet.
  rr_pick #(.N(NUM_IN)) u_pick (
    .i_req    (route_req & w_head),
    .i_ptr    (r_rr_ptr),
    .o_onehot (w_pick_onehot),
    .o_idx    (w_pick_idx),
    .o_valid  (w_pick_valid)
  );

  assign w_grant_req = route_req[r_grant_id];
  assign w_sel_idx   = (r_state == IDLE) ? w_pick_idx : r_grant_id;
  assign w_tail_done = (r_state == SEND) && r_out_req && in_ack && r_out_flit[TAIL_BIT];

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_bubble    = 1'b0;
    w_src_ack   = '0;
    w_orphan    = 1'b0;
    case (r_state)
      IDLE: begin
        w_orphan = |(route_req & ~w_head);
        if (w_pick_valid) begin
          w_load      = 1'b1;
          w_src_ack   = w_pick_onehot;
          w_state_nxt = SEND;
        end
      end
      SEND: begin
        if (w_tail_done) begin
          w_state_nxt = IDLE;
        end else if (r_out_req && in_ack) begin
          if (w_grant_req) begin
            w_load    = 1'b1;
            w_src_ack = w_grant_onehot;
          end else begin
            w_bubble    = 1'b1;
            w_state_nxt = WAIT_BODY;
          end
        end
      end
      WAIT_BODY: begin
        if (w_grant_req) begin
          w_load      = 1'b1;
          w_src_ack   = w_grant_onehot;
          w_state_nxt = SEND;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_rr_ptr   <= '0;
      r_out_flit <= '0;
      r_out_req  <= 1'b0;
      r_grant_id <= '0;
      r_busy     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_out_flit <= w_sel_flit;
        r_out_req  <= 1'b1;
      end else if (w_tail_done || w_bubble) begin
        r_out_req  <= 1'b0;
      end
      if (r_state == IDLE && w_pick_valid) begin
        r_grant_id <= w_pick_idx;
        r_busy     <= 1'b1;
      end
      if (w_tail_done) begin
        r_busy   <= 1'b0;
        r_rr_ptr <= rr_next(r_grant_id, NUM_IN);
      end
    end
  end

  // Acks and error pulses are combinational so upstream pops in the same
  // cycle the flit is captured; they are forced low while reset is held.
  assign src_ack    = rst ? w_src_ack : '0;
  assign err_orphan = rst ? w_orphan : 1'b0;
  assign out_flit   = r_out_flit;
  assign out_req    = r_out_req;
  assign grant_id   = r_grant_id;
  assign busy       = r_busy;

`ifdef ARB_PERF_CNT_EN
  logic [15:0] r_pkt_cnt, r_stall_cnt;

  // Stall counts only cycles where the locked input has nothing to send.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pkt_cnt   <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_tail_done && r_pkt_cnt != 16'hFFFF) r_pkt_cnt <= r_pkt_cnt + 16'd1;
      if (r_state == WAIT_BODY && !w_grant_req && r_stall_cnt != 16'hFFFF)
        r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign pkt_cnt   = r_pkt_cnt;
  assign stall_cnt = r_stall_cnt;
`else
  assign pkt_cnt   = '0;
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_noc_output_port_arbiter.sv
// tb/tb_noc_output_port_arbiter.sv - directed self-checking bench for noc_output_port_arbiter
module tb_noc_output_port_arbiter;
  import noc_pkg::*;

  localparam int N = 5;
  localparam int W = 34;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   route_req;
  logic [N*W-1:0] in_flit;
  logic [N-1:0]   src_ack;
  logic [W-1:0]   out_flit;
  logic           out_req;
  logic           in_ack;
  logic [2:0]     grant_id;
  logic           busy;
  logic           err_orphan;
  logic [15:0]    pkt_cnt;
  logic [15:0]    stall_cnt;

  logic [W-1:0]   f [N];
  logic [W-1:0]   m_flit;
  logic [W-1:0]   e_flit;
  int             n_checks = 0;
  int             n_errors = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) in_flit[i*W +: W] = f[i];
  end

  noc_output_port_arbiter #(.NUM_IN(N), .FLIT_W(W), .PORT_ID(0)) dut (
    .clk        (clk),
    .rst        (rst),
    .route_req  (route_req),
    .in_flit    (in_flit),
    .src_ack    (src_ack),
    .out_flit   (out_flit),
    .out_req    (out_req),
    .in_ack     (in_ack),
    .grant_id   (grant_id),
    .busy       (busy),
    .err_orphan (err_orphan),
    .pkt_cnt    (pkt_cnt),
    .stall_cnt  (stall_cnt)
  );

  typedef struct {
    logic       rst;
    logic [4:0] req;
    logic [4:0] head;
    logic [4:0] tail;
    logic       ack;
    logic [4:0] e_ack;
    logic       e_orph;
    logic       e_req;
    logic       e_busy;
    logic [2:0] e_gid;   // 7 = not checked
    logic [2:0] e_load;  // input whose flit gets captured; 7 = none
  } vec_t;

  vec_t tbl [18];

  function automatic logic [W-1:0] mkflit(input logic h, input logic t, input logic [3:0] dst,
                                          input logic [23:0] pl);
    return {h, t, 4'h0, dst, pl};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input int i, input logic r, input logic h, input logic t, input logic [23:0] pl);
    route_req[i] = r;
    f[i] = mkflit(h, t, 4'(i), pl);
  endtask

  task automatic clr_in();
    route_req = '0;
    for (int i = 0; i < N; i++) f[i] = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1, "watchdog");
  end

  initial begin
    //         rst  req       head      tail      ack  e_ack    orph req  busy gid   load
    tbl[0]  = '{1'b0, 5'b11111, 5'b11111, 5'b00000, 1'b0, 5'b00000, 1'b0, 1'b0, 1'b0, 3'd0, 3'd7};
    tbl[1]  = '{1'b0, 5'b11111, 5'b11111, 5'b00000, 1'b0, 5'b00000, 1'b0, 1'b0, 1'b0, 3'd0, 3'd7};
    tbl[2]  = '{1'b1, 5'b11111, 5'b11111, 5'b00000, 1'b0, 5'b00001, 1'b0, 1'b1, 1'b1, 3'd0, 3'd0};
    tbl[3]  = '{1'b1, 5'b11111, 5'b11111, 5'b00000, 1'b0, 5'b00000, 1'b0, 1'b1, 1'b1, 3'd0, 3'd7};
    tbl[4]  = '{1'b1, 5'b11111, 5'b11110, 5'b00001, 1'b1, 5'b00001, 1'b0, 1'b1, 1'b1, 3'd0, 3'd0};
    tbl[5]  = '{1'b1, 5'b00000, 5'b00000, 5'b00000, 1'b1, 5'b00000, 1'b0, 1'b0, 1'b0, 3'd7, 3'd7};
    tbl[6]  = '{1'b1, 5'b01010, 5'b01010, 5'b01010, 1'b1, 5'b00010, 1'b0, 1'b1, 1'b1, 3'd1, 3'd1};
    tbl[7]  = '{1'b1, 5'b01010, 5'b01010, 5'b01010, 1'b1, 5'b00000, 1'b0, 1'b0, 1'b0, 3'd7, 3'd7};
    tbl[8]  = '{1'b1, 5'b01010, 5'b01010, 5'b01010, 1'b1, 5'b01000, 1'b0, 1'b1, 1'b1, 3'd3, 3'd3};
    tbl[9]  = '{1'b1, 5'b01010, 5'b01010, 5'b01010, 1'b1, 5'b00000, 1'b0, 1'b0, 1'b0, 3'd7, 3'd7};
    tbl[10] = '{1'b1, 5'b01010, 5'b01010, 5'b01010, 1'b1, 5'b00010, 1'b0, 1'b1, 1'b1, 3'd1, 3'd1};
    tbl[11] = '{1'b1, 5'b01010, 5'b01010, 5'b01010, 1'b1, 5'b00000, 1'b0, 1'b0, 1'b0, 3'd7, 3'd7};
    tbl[12] = '{1'b1, 5'b01010, 5'b01010, 5'b01010, 1'b1, 5'b01000, 1'b0, 1'b1, 1'b1, 3'd3, 3'd3};
    tbl[13] = '{1'b1, 5'b01010, 5'b01010, 5'b01010, 1'b1, 5'b00000, 1'b0, 1'b0, 1'b0, 3'd7, 3'd7};
    tbl[14] = '{1'b1, 5'b00100, 5'b00000, 5'b00000, 1'b0, 5'b00000, 1'b1, 1'b0, 1'b0, 3'd7, 3'd7};
    tbl[15] = '{1'b1, 5'b00101, 5'b00001, 5'b00001, 1'b0, 5'b00001, 1'b1, 1'b1, 1'b1, 3'd0, 3'd0};
    tbl[16] = '{1'b1, 5'b00000, 5'b00000, 5'b00000, 1'b1, 5'b00000, 1'b0, 1'b0, 1'b0, 3'd7, 3'd7};
    tbl[17] = '{1'b1, 5'b00000, 5'b00000, 5'b00000, 1'b1, 5'b00000, 1'b0, 1'b0, 1'b0, 3'd7, 3'd7};

    m_flit = '0;
    clr_in();
    rst = 1'b0;
    in_ack = 1'b0;

    // Reset, first grant, back-to-back, round-robin fairness, orphan detection.
    for (int v = 0; v < 18; v++) begin
      rst    = tbl[v].rst;
      in_ack = tbl[v].ack;
      for (int i = 0; i < N; i++) begin
        route_req[i] = tbl[v].req[i];
        f[i] = mkflit(tbl[v].head[i], tbl[v].tail[i], 4'(i), 24'(v*16 + i));
      end
      #1;
      chk($sformatf("tbl%0d_src_ack", v), src_ack, tbl[v].e_ack);
      chk($sformatf("tbl%0d_err_orphan", v), err_orphan, tbl[v].e_orph);
      if (tbl[v].e_load != 3'd7) m_flit = f[tbl[v].e_load];
      cyc();
      chk($sformatf("tbl%0d_out_req", v), out_req, tbl[v].e_req);
      chk($sformatf("tbl%0d_busy", v), busy, tbl[v].e_busy);
      if (tbl[v].e_gid != 3'd7) chk($sformatf("tbl%0d_grant_id", v), grant_id, tbl[v].e_gid);
      chk($sformatf("tbl%0d_out_flit", v), out_flit, m_flit);
    end

    // Wormhole: input 2 owns the port for four flits while input 4 waits.
    clr_in();
    in_ack = 1'b1;
    set_in(2, 1'b1, 1'b1, 1'b0, 24'h200);
    set_in(4, 1'b1, 1'b1, 1'b1, 24'h400);
    #1 chk("wh_head_ack", src_ack, 5'b00100);
    e_flit = f[2];
    cyc();
    chk("wh_flit0", out_flit, e_flit);
    chk("wh_grant", grant_id, 3'd2);
    for (int k = 1; k < 4; k++) begin
      set_in(2, 1'b1, 1'b0, (k == 3), 24'h200 + 24'(k));
      #1 chk($sformatf("wh_body%0d_ack", k), src_ack, 5'b00100);
      e_flit = f[2];
      cyc();
      chk($sformatf("wh_flit%0d", k), out_flit, e_flit);
    end
    set_in(2, 1'b0, 1'b0, 1'b0, 24'h0);
    #1 chk("wh_tail_no_ack", src_ack, 5'b00000);
    cyc();
    chk("wh_release_busy", busy, 1'b0);
    chk("wh_release_req", out_req, 1'b0);
    #1 chk("wh_next_ack", src_ack, 5'b10000);
    cyc();
    chk("wh_next_grant", grant_id, 3'd4);
    set_in(4, 1'b0, 1'b0, 1'b0, 24'h0);
    #1 cyc();
    chk("wh_next_release", busy, 1'b0);

    // Fresh reset so the counters start from zero for the bubble case.
    rst = 1'b0;
    clr_in();
    cyc();
    cyc();
    rst = 1'b1;
    chk("rst_pkt_cnt", pkt_cnt, 16'd0);
    chk("rst_stall_cnt", stall_cnt, 16'd0);

    // Bubble: input 1 pauses 3 cycles after its head; input 3 must stay locked out.
    set_in(1, 1'b1, 1'b1, 1'b0, 24'h110);
    set_in(3, 1'b1, 1'b1, 1'b0, 24'h330);
    #1 chk("bub_head_ack", src_ack, 5'b00010);
    cyc();
    chk("bub_grant", grant_id, 3'd1);
    set_in(1, 1'b0, 1'b0, 1'b0, 24'h0);
    #1 chk("bub_drop_ack", src_ack, 5'b00000);
    cyc();
    chk("bub_wait_req", out_req, 1'b0);
    chk("bub_wait_busy", busy, 1'b1);
    for (int k = 0; k < 3; k++) begin
      #1 chk($sformatf("bub_idle%0d_ack", k), src_ack, 5'b00000);
      cyc();
      chk($sformatf("bub_idle%0d_req", k), out_req, 1'b0);
      chk($sformatf("bub_idle%0d_busy", k), busy, 1'b1);
    end
    set_in(1, 1'b1, 1'b0, 1'b0, 24'h111);
    #1 chk("bub_resume_ack", src_ack, 5'b00010);
    e_flit = f[1];
    cyc();
    chk("bub_resume_req", out_req, 1'b1);
    chk("bub_resume_flit", out_flit, e_flit);
`ifdef ARB_PERF_CNT_EN
    chk("bub_stall_cnt", stall_cnt, 16'd3);
`else
    chk("bub_stall_cnt", stall_cnt, 16'd0);
`endif
    set_in(1, 1'b1, 1'b0, 1'b1, 24'h112);
    #1 chk("bub_tail_ack", src_ack, 5'b00010);
    e_flit = f[1];
    cyc();
    chk("bub_tail_flit", out_flit, e_flit);
    set_in(1, 1'b0, 1'b0, 1'b0, 24'h0);
    #1 chk("bub_done_ack", src_ack, 5'b00000);
    cyc();
    chk("bub_done_busy", busy, 1'b0);
`ifdef ARB_PERF_CNT_EN
    chk("bub_pkt_cnt", pkt_cnt, 16'd1);
`else
    chk("bub_pkt_cnt", pkt_cnt, 16'd0);
`endif

    // Backpressure: input 3 (still waiting) gets the port; in_ack withheld 5 cycles.
    #1 chk("bp_head_ack", src_ack, 5'b01000);
    e_flit = f[3];
    cyc();
    chk("bp_grant", grant_id, 3'd3);
    set_in(3, 1'b1, 1'b0, 1'b0, 24'h331);
    in_ack = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1 chk($sformatf("bp_hold%0d_ack", k), src_ack, 5'b00000);
      cyc();
      chk($sformatf("bp_hold%0d_flit", k), out_flit, e_flit);
      chk($sformatf("bp_hold%0d_req", k), out_req, 1'b1);
    end
    in_ack = 1'b1;
    #1 chk("bp_body_ack", src_ack, 5'b01000);
    e_flit = f[3];
    cyc();
    chk("bp_body_flit", out_flit, e_flit);
    in_ack = 1'b0;
    #1 chk("bp_hold_again_ack", src_ack, 5'b00000);
    cyc();
    chk("bp_hold_again_flit", out_flit, e_flit);
    in_ack = 1'b1;
    set_in(3, 1'b1, 1'b0, 1'b1, 24'h332);
    #1 chk("bp_tail_ack", src_ack, 5'b01000);
    e_flit = f[3];
    cyc();
    chk("bp_tail_flit", out_flit, e_flit);
    set_in(3, 1'b0, 1'b0, 1'b0, 24'h0);
    #1 chk("bp_done_ack", src_ack, 5'b00000);
    cyc();
    chk("bp_done_busy", busy, 1'b0);

    // Reset mid-packet: lock dropped and rr pointer back to 0 (it was 4).
    set_in(0, 1'b1, 1'b1, 1'b0, 24'h000);
    #1 chk("mr_head_ack", src_ack, 5'b00001);
    cyc();
    chk("mr_busy", busy, 1'b1);
    rst = 1'b0;
    in_ack = 1'b0;
    #1 chk("mr_rst_ack", src_ack, 5'b00000);
    cyc();
    chk("mr_rst_busy", busy, 1'b0);
    chk("mr_rst_req", out_req, 1'b0);
    chk("mr_rst_flit", out_flit, 34'd0);
    rst = 1'b1;
    set_in(0, 1'b0, 1'b0, 1'b0, 24'h0);
    set_in(1, 1'b1, 1'b1, 1'b1, 24'h150);
    set_in(4, 1'b1, 1'b1, 1'b1, 24'h450);
    #1 chk("mr_rr_ptr_ack", src_ack, 5'b00010);
    cyc();
    chk("mr_rr_ptr_grant", grant_id, 3'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
